// File: rtl/timer_6502_pkg.sv
// Shared definitions for the 6502 interval timer.
// Holds the register address map, the CTRL bit positions and the STAT
// timeout-flag position used by the timer top and by software-facing logic.
package timer_6502_pkg;

    // Register addresses (CPU_AB[2:0])
    localparam logic [2:0] TMR_CTRL  = 3'd0;
    localparam logic [2:0] TMR_STAT  = 3'd1;
    localparam logic [2:0] TMR_RLD_L = 3'd2;
    localparam logic [2:0] TMR_RLD_H = 3'd3;
    localparam logic [2:0] TMR_CNT_L = 3'd4;
    localparam logic [2:0] TMR_CNT_H = 3'd5;
    localparam logic [2:0] TMR_PRE   = 3'd6;

    // CTRL bit positions
    localparam int EN_BIT   = 0;
    localparam int CONT_BIT = 1;
    localparam int IE_BIT   = 2;

    // STAT bit positions
    localparam int TF_BIT   = 0;

endpackage

// File: rtl/timer_prescaler.sv
// 8-bit prescaler for the 6502 interval timer.
// Counts down from the divide value while enabled and raises tick for one
// clock whenever the count sits at zero, reloading the divide value then.
// Ports:
//   clk     - system clock
//   reset   - asynchronous, active-high reset
//   en      - count enable (timer EN)
//   restart - reload the count from pre immediately
//   pre     - divide value (tick every pre+1 enabled clocks)
//   tick    - one-clock pulse when the count expires
module timer_prescaler #(
    parameter logic [7:0] PRE_RST = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       restart,
    input  logic [7:0] pre,
    output logic       tick
);

    logic [7:0] count;

    // Tick is decoded straight from the count flop, so it is glitch-free
    // and occupies exactly the cycle in which the count is zero.
    assign tick = en & (count == 8'd0);

    // Prescaler count register; restart has priority over normal counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= PRE_RST;
        end else if (restart) begin
            count <= pre;
        end else if (en) begin
            if (count == 8'd0) begin
                count <= pre;
            end else begin
                count <= count - 8'd1;
            end
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/timer_6502.sv
// Memory-mapped 16-bit programmable interval timer for the 6502 bus.
// Provides a prescaled 16-bit down-counter with one-shot or continuous
// reload, a coherent two-byte counter read via a high-byte latch, and a
// level interrupt.
// Ports:
//   clk   - system / CPU clock
//   reset - asynchronous, active-high reset
//   cs    - chip select (page decode)
//   we    - write enable, qualified by cs
//   addr  - register select
//   din   - write data
//   dout  - registered read data, valid the cycle after addr
//   irq   - level interrupt request (TF & IE)
module timer_6502
    import timer_6502_pkg::*;
#(
    parameter logic [7:0]  PRE_RST = 8'h00,
    parameter logic [15:0] RLD_RST = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cs,
    input  logic       we,
    input  logic [2:0] addr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       irq
);

    logic        en;
    logic        cont;
    logic        ie;
    logic        tf;
    logic [15:0] rld;
    logic [7:0]  rld_lo;
    logic [15:0] cnt;
    logic [7:0]  pre;
    logic [7:0]  hlatch;
    logic [7:0]  rdata;
    logic        tick;
    logic        restart;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        wr_rld_l;
    logic        wr_rld_h;
    logic        wr_pre;
    logic        rd_cnt_l;
    logic        timeout;

    assign wr_ctrl  = cs & we & (addr == TMR_CTRL);
    assign wr_stat  = cs & we & (addr == TMR_STAT);
    assign wr_rld_l = cs & we & (addr == TMR_RLD_L);
    assign wr_rld_h = cs & we & (addr == TMR_RLD_H);
    assign wr_pre   = cs & we & (addr == TMR_PRE);
    // Dummy reads count too: any qualified read of CNT_L snapshots the high byte.
    assign rd_cnt_l = cs & ~we & (addr == TMR_CNT_L);

    // A reload write on a tick cycle suppresses the expiry entirely.
    assign timeout  = tick & (cnt == 16'd0) & ~wr_rld_h;

    // The prescaler restarts on a reload commit or when EN goes 0 -> 1.
    assign restart  = wr_rld_h | (wr_ctrl & din[EN_BIT] & ~en);

    assign irq      = tf & ie;

    timer_prescaler #(
        .PRE_RST(PRE_RST)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .restart(restart),
        .pre    (pre),
        .tick   (tick)
    );

    // CTRL register; a CPU write beats the one-shot auto-clear of EN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en   <= 1'b0;
            cont <= 1'b0;
            ie   <= 1'b0;
        end else if (wr_ctrl) begin
            en   <= din[EN_BIT];
            cont <= din[CONT_BIT];
            ie   <= din[IE_BIT];
        end else if (timeout && !cont) begin
            en   <= 1'b0;
        end else begin
            en   <= en;
        end
    end

    // Timeout flag; setting beats a coincident write-1-clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tf <= 1'b0;
        end else if (timeout) begin
            tf <= 1'b1;
        end else if (wr_stat && din[TF_BIT]) begin
            tf <= 1'b0;
        end else begin
            tf <= tf;
        end
    end

    // Reload staging, reload register and prescaler divide value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rld_lo <= RLD_RST[7:0];
            rld    <= RLD_RST;
            pre    <= PRE_RST;
        end else begin
            if (wr_rld_l) begin
                rld_lo <= din;
            end else begin
                rld_lo <= rld_lo;
            end
            if (wr_rld_h) begin
                rld <= {din, rld_lo};
            end else begin
                rld <= rld;
            end
            if (wr_pre) begin
                pre <= din;
            end else begin
                pre <= pre;
            end
        end
    end

    // Main down-counter; a reload commit takes priority over a tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= RLD_RST;
        end else if (wr_rld_h) begin
            cnt <= {din, rld_lo};
        end else if (tick) begin
            if (cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end else if (cont) begin
                cnt <= rld;
            end else begin
                cnt <= cnt;
            end
        end else begin
            cnt <= cnt;
        end
    end

    // High-byte latch so a CNT_L then CNT_H read pair sees one coherent value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hlatch <= 8'h00;
        end else if (rd_cnt_l) begin
            hlatch <= cnt[15:8];
        end else begin
            hlatch <= hlatch;
        end
    end

    // Read mux, decoded from addr every cycle regardless of cs.
    always_comb begin
        rdata = 8'h00;
        case (addr)
            TMR_CTRL:  rdata = {5'b00000, ie, cont, en};
            TMR_STAT:  rdata = {7'b0000000, tf};
            TMR_RLD_L: rdata = rld_lo;
            TMR_RLD_H: rdata = rld[15:8];
            TMR_CNT_L: rdata = cnt[7:0];
            TMR_CNT_H: rdata = hlatch;
            TMR_PRE:   rdata = pre;
            default:   rdata = 8'h00;
        endcase
    end

    // Registered read data, one clock behind the address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout <= 8'h00;
        end else begin
            dout <= rdata;
        end
    end

endmodule
